// File: rtl/exmem_reg_pkg.sv
// Shared types for the EX/MEM pipeline register: datapath words, register
// selects and the latched stage record.
package exmem_reg_pkg;

   localparam int WORD_W = 32;
   localparam int REG_W  = 5;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [REG_W-1:0]  regbits_t;

   // Bit 0 is the read request and bit 1 the write request, so the state
   // register doubles as the registered dcache request lines.
   typedef enum logic [1:0] {
      REQ_IDLE  = 2'b00,
      REQ_READ  = 2'b01,
      REQ_WRITE = 2'b10,
      REQ_BOTH  = 2'b11
   } req_state_t;

   typedef struct packed {
      word_t    pcplus4;
      word_t    aluout;
      word_t    rdat2;
      regbits_t wsel;
      logic     mem_to_reg;
      logic     reg_wen;
      logic     jal;
      logic     halt;
   } exmem_stage_t;

   localparam exmem_stage_t STAGE_BUBBLE = '0;

   function automatic req_state_t req_from_bits(input logic ren, input logic wen);
      return req_state_t'({wen, ren});
   endfunction

endpackage

// File: rtl/exmem_reg_if.sv
// Bundle of every EX/MEM register signal except clock and reset; the exmem
// side is the register itself, the tb side drives it.
interface exmem_reg_if;
   import exmem_reg_pkg::*;

   logic     ihit;
   logic     dhit;
   logic     flush;

   word_t    pcplus4_in;
   word_t    aluout_in;
   word_t    rdat2_in;
   regbits_t wsel_in;
   word_t    dmemload_in;
   logic     MemToReg_in;
   logic     regWEN_in;
   logic     JAL_in;
   logic     Halt_in;
   logic     dMemREN_in;
   logic     dMemWEN_in;

   word_t    pcplus4_out;
   word_t    aluout_out;
   word_t    rdat2_out;
   regbits_t wsel_out;
   word_t    dload_out;
   logic     MemToReg_out;
   logic     regWEN_out;
   logic     JAL_out;
   logic     Halt_out;
   logic     dMemREN_out;
   logic     dMemWEN_out;
   logic     mem_busy;

   modport exmem (
      input  ihit, dhit, flush,
      input  pcplus4_in, aluout_in, rdat2_in, wsel_in, dmemload_in,
      input  MemToReg_in, regWEN_in, JAL_in, Halt_in, dMemREN_in, dMemWEN_in,
      output pcplus4_out, aluout_out, rdat2_out, wsel_out, dload_out,
      output MemToReg_out, regWEN_out, JAL_out, Halt_out,
      output dMemREN_out, dMemWEN_out, mem_busy
   );

   modport tb (
      output ihit, dhit, flush,
      output pcplus4_in, aluout_in, rdat2_in, wsel_in, dmemload_in,
      output MemToReg_in, regWEN_in, JAL_in, Halt_in, dMemREN_in, dMemWEN_in,
      input  pcplus4_out, aluout_out, rdat2_out, wsel_out, dload_out,
      input  MemToReg_out, regWEN_out, JAL_out, Halt_out,
      input  dMemREN_out, dMemWEN_out, mem_busy
   );

endinterface

// File: rtl/exmem_reg_dmem_req_tracker.sv
// Data-memory request tracker: issues the dcache request on advance, drops it
// on dhit and holds the returned load data until the pipeline moves on.
module exmem_reg_dmem_req_tracker
   import exmem_reg_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  advance,
   input  logic  flush,
   input  logic  ren_in,
   input  logic  wen_in,
   input  logic  dhit,
   input  word_t dmemload_in,
   output logic  dmem_ren,
   output logic  dmem_wen,
   output word_t dload,
   output logic  mem_busy
);

   req_state_t state_reg;
   req_state_t state_next;
   word_t      dload_reg;
   word_t      dload_next;
   logic       pending;
   logic       is_read;

   assign pending = (state_reg != REQ_IDLE);
   assign is_read = (state_reg == REQ_READ) || (state_reg == REQ_BOTH);

   always_comb begin
      state_next = state_reg;
      dload_next = dload_reg;
      if (advance) begin
         state_next = flush ? REQ_IDLE : req_from_bits(ren_in, wen_in);
         dload_next = '0;
      end else if (dhit && pending) begin
         // Completed request is retired so it is never reissued during the ihit wait.
         state_next = REQ_IDLE;
         if (is_read) begin
            dload_next = dmemload_in;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= REQ_IDLE;
         dload_reg <= '0;
      end else begin
         state_reg <= state_next;
         dload_reg <= dload_next;
      end
   end

   assign dmem_ren = is_read;
   assign dmem_wen = (state_reg == REQ_WRITE) || (state_reg == REQ_BOTH);
   assign dload    = dload_reg;
   assign mem_busy = pending & ~dhit;

endmodule

// File: rtl/exmem_reg.sv
// EX/MEM pipeline register with sticky halt, bubble insertion on flush and a
// dedicated dcache request tracker.
module exmem_reg
   import exmem_reg_pkg::*;
(
   input logic        CLK,
   input logic        RST,
   exmem_reg_if.exmem bus
);

   exmem_stage_t stage_reg;
   exmem_stage_t stage_next;
   exmem_stage_t stage_in;
   logic         advance;
   logic         mem_busy;
   logic         dmem_ren;
   logic         dmem_wen;
   word_t        dload;

   assign stage_in = '{
      pcplus4:    bus.pcplus4_in,
      aluout:     bus.aluout_in,
      rdat2:      bus.rdat2_in,
      wsel:       bus.wsel_in,
      mem_to_reg: bus.MemToReg_in,
      reg_wen:    bus.regWEN_in,
      jal:        bus.JAL_in,
      halt:       bus.Halt_in
   };

   // A latched halt blocks every further advance until reset.
   assign advance = bus.ihit & ~mem_busy & ~stage_reg.halt;

   always_comb begin
      stage_next = stage_reg;
      if (advance) begin
         stage_next = bus.flush ? STAGE_BUBBLE : stage_in;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stage_reg <= STAGE_BUBBLE;
      end else begin
         stage_reg <= stage_next;
      end
   end

   exmem_reg_dmem_req_tracker dmem_req_tracker (
      .clk         (CLK),
      .rst         (RST),
      .advance     (advance),
      .flush       (bus.flush),
      .ren_in      (bus.dMemREN_in),
      .wen_in      (bus.dMemWEN_in),
      .dhit        (bus.dhit),
      .dmemload_in (bus.dmemload_in),
      .dmem_ren    (dmem_ren),
      .dmem_wen    (dmem_wen),
      .dload       (dload),
      .mem_busy    (mem_busy)
   );

   assign bus.pcplus4_out  = stage_reg.pcplus4;
   assign bus.aluout_out   = stage_reg.aluout;
   assign bus.rdat2_out    = stage_reg.rdat2;
   assign bus.wsel_out     = stage_reg.wsel;
   assign bus.MemToReg_out = stage_reg.mem_to_reg;
   assign bus.regWEN_out   = stage_reg.reg_wen;
   assign bus.JAL_out      = stage_reg.jal;
   assign bus.Halt_out     = stage_reg.halt;
   assign bus.dMemREN_out  = dmem_ren;
   assign bus.dMemWEN_out  = dmem_wen;
   assign bus.dload_out    = dload;
   assign bus.mem_busy     = mem_busy;

endmodule

// File: tb/tb_exmem_reg.sv
// Directed bench for exmem_reg: expected output snapshots are queued as each
// step is driven and compared on the falling edge.
module tb_exmem_reg;
   import exmem_reg_pkg::*;

   typedef struct packed {
      word_t    pcplus4;
      word_t    aluout;
      word_t    rdat2;
      regbits_t wsel;
      word_t    dload;
      logic     mtr;
      logic     rwen;
      logic     jal;
      logic     halt;
      logic     ren;
      logic     wen;
      logic     busy;
   } outs_t;

   logic CLK;
   logic RST;
   int   vectors;
   int   miscompares;
   outs_t exp_q[$];
   outs_t e;

   exmem_reg_if bus();

   exmem_reg dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   function automatic outs_t sample();
      outs_t s;
      s.pcplus4 = bus.pcplus4_out;
      s.aluout  = bus.aluout_out;
      s.rdat2   = bus.rdat2_out;
      s.wsel    = bus.wsel_out;
      s.dload   = bus.dload_out;
      s.mtr     = bus.MemToReg_out;
      s.rwen    = bus.regWEN_out;
      s.jal     = bus.JAL_out;
      s.halt    = bus.Halt_out;
      s.ren     = bus.dMemREN_out;
      s.wen     = bus.dMemWEN_out;
      s.busy    = bus.mem_busy;
      return s;
   endfunction

   task automatic clear_inputs();
      bus.ihit        = 1'b0;
      bus.dhit        = 1'b0;
      bus.flush       = 1'b0;
      bus.pcplus4_in  = '0;
      bus.aluout_in   = '0;
      bus.rdat2_in    = '0;
      bus.wsel_in     = '0;
      bus.dmemload_in = '0;
      bus.MemToReg_in = 1'b0;
      bus.regWEN_in   = 1'b0;
      bus.JAL_in      = 1'b0;
      bus.Halt_in     = 1'b0;
      bus.dMemREN_in  = 1'b0;
      bus.dMemWEN_in  = 1'b0;
   endtask

   // Compare the oldest queued expectation against the outputs seen now.
   task automatic step(input string tag);
      outs_t got;
      outs_t want;
      #1;
      assert (!(bus.dMemREN_in && bus.dMemWEN_in)) else begin
         miscompares++;
         $error("FAIL %s illegal_req: observed ren=1 wen=1, expected at most one", tag);
      end
      got = sample();
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $error("FAIL %s: observed empty scoreboard, expected a queued vector", tag);
      end else begin
         want = exp_q.pop_front();
         assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
         end
      end
      $display("vec %0d %s: alu=%h wsel=%0d dload=%h ren=%b wen=%b busy=%b halt=%b",
               vectors, tag, got.aluout, got.wsel, got.dload, got.ren, got.wen,
               got.busy, got.halt);
      @(negedge CLK);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      RST         = 1'b1;
      clear_inputs();
      e = '0;
      @(negedge CLK);
      exp_q.push_back(e); step("reset");

      // First advance after reset.
      RST = 1'b0;
      bus.ihit = 1'b1; bus.aluout_in = 32'h0000_0040;
      exp_q.push_back(e); step("adv_pre");

      // Issue a load, then wait three cycles on dcache with ihit low.
      bus.dMemREN_in = 1'b1; bus.aluout_in = 32'h100; bus.wsel_in = 5'd3;
      bus.regWEN_in = 1'b1; bus.MemToReg_in = 1'b1; bus.pcplus4_in = 32'h8;
      e.aluout = 32'h40;
      exp_q.push_back(e); step("adv_0x40");

      clear_inputs();
      e = '0; e.aluout = 32'h100; e.wsel = 5'd3; e.rwen = 1'b1; e.mtr = 1'b1;
      e.pcplus4 = 32'h8; e.ren = 1'b1; e.busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(e); step("ld_wait");
      end

      bus.dhit = 1'b1; bus.dmemload_in = 32'hDEAD_BEEF;
      e.busy = 1'b0;
      exp_q.push_back(e); step("ld_dhit");

      bus.dhit = 1'b0; bus.dmemload_in = 32'h0;
      e.ren = 1'b0; e.dload = 32'hDEAD_BEEF;
      exp_q.push_back(e); step("ld_data");
      exp_q.push_back(e); step("ld_hold");

      // Store, then dhit and ihit together with the next instruction.
      bus.ihit = 1'b1; bus.dMemWEN_in = 1'b1; bus.rdat2_in = 32'hCAFE_F00D;
      bus.aluout_in = 32'h200;
      exp_q.push_back(e); step("st_issue");

      clear_inputs();
      e = '0; e.aluout = 32'h200; e.rdat2 = 32'hCAFE_F00D; e.wen = 1'b1; e.busy = 1'b1;
      exp_q.push_back(e); step("st_busy");

      bus.dhit = 1'b1; bus.ihit = 1'b1; bus.regWEN_in = 1'b1; bus.wsel_in = 5'd5;
      bus.aluout_in = 32'h300;
      e.busy = 1'b0;
      exp_q.push_back(e); step("st_dhit_ihit");

      clear_inputs();
      e = '0; e.rwen = 1'b1; e.wsel = 5'd5; e.aluout = 32'h300;
      exp_q.push_back(e); step("st_next");

      // Flush without advance is ignored, with advance it loads a bubble.
      bus.flush = 1'b1; bus.regWEN_in = 1'b1; bus.Halt_in = 1'b1; bus.aluout_in = 32'h77;
      bus.JAL_in = 1'b1; bus.wsel_in = 5'd7;
      exp_q.push_back(e); step("fl_noadv_a");
      exp_q.push_back(e); step("fl_noadv_b");

      bus.ihit = 1'b1;
      exp_q.push_back(e); step("fl_adv");

      clear_inputs();
      e = '0;
      exp_q.push_back(e); step("fl_bubble");

      // Stall hold: pending load with ihit high and no dhit.
      bus.ihit = 1'b1; bus.dMemREN_in = 1'b1; bus.aluout_in = 32'h400;
      bus.wsel_in = 5'd9; bus.regWEN_in = 1'b1; bus.MemToReg_in = 1'b1;
      exp_q.push_back(e); step("stl_issue");

      bus.dMemREN_in = 1'b0; bus.aluout_in = 32'h555; bus.wsel_in = 5'd10;
      bus.regWEN_in = 1'b0; bus.MemToReg_in = 1'b0;
      e.aluout = 32'h400; e.wsel = 5'd9; e.rwen = 1'b1; e.mtr = 1'b1;
      e.ren = 1'b1; e.busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(e); step("stl_hold");
      end

      // Asynchronous reset while the load is still outstanding.
      clear_inputs();
      RST = 1'b1;
      e = '0;
      exp_q.push_back(e); step("rst_mid");

      RST = 1'b0;
      bus.ihit = 1'b1; bus.aluout_in = 32'h0000_0040;
      exp_q.push_back(e); step("rst_rel");

      clear_inputs();
      e.aluout = 32'h40;
      exp_q.push_back(e); step("rst_adv");

      // Halt is sticky and freezes every field.
      bus.ihit = 1'b1; bus.Halt_in = 1'b1; bus.pcplus4_in = 32'h1234;
      exp_q.push_back(e); step("h_issue");

      bus.Halt_in = 1'b0; bus.aluout_in = 32'h55; bus.regWEN_in = 1'b1;
      bus.pcplus4_in = 32'h9999;
      e = '0; e.pcplus4 = 32'h1234; e.halt = 1'b1;
      exp_q.push_back(e); step("h_set");
      exp_q.push_back(e); step("h_stick_a");
      exp_q.push_back(e); step("h_stick_b");

      // dhit with nothing pending changes nothing.
      bus.dhit = 1'b1; bus.dmemload_in = 32'h1111_2222;
      exp_q.push_back(e); step("h_dhit");
      bus.dhit = 1'b0;
      exp_q.push_back(e); step("h_after_dhit");

      RST = 1'b1;
      e = '0;
      exp_q.push_back(e); step("h_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
